// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: widths, reset PC, bubble encoding, fetch states.
package cpu_pkg;
  localparam int unsigned XLEN = 16;
  localparam logic [XLEN-1:0] NOP_INSTR = 16'h0000;
  localparam logic [XLEN-1:0] RESET_PC = 16'h0000;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc} buffer that parks a read response arriving while IF/ID is stalled.
module fetch_hold_buf #(
  parameter int unsigned XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            hold_valid
);

  // clear beats load beats drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      instr      <= '0;
      pc         <= '0;
    end else if (clear) begin
      hold_valid <= 1'b0;
    end else if (load) begin
      hold_valid <= 1'b1;
      instr      <= load_instr;
      pc         <= load_pc;
    end else if (drain) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, instruction-memory issue, stall hold buffer and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module fetch_stage #(
  parameter int unsigned      XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [XLEN-1:0]  NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            ifid_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic            ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);
  import cpu_pkg::*;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic            hold_valid;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic            load_hold;
  logic            drain_hold;

  // No new fetch while a parked response is waiting or a redirect is in progress
  assign imem_req   = rst_n & pc_write & ~redirect_valid & ~hold_valid;
  assign imem_addr  = pc;
  assign load_hold  = (state == RUN) & ~ifid_write & inflight & ~redirect_valid;
  assign drain_hold = (state == HOLD) & ifid_write & ~redirect_valid;

  fetch_hold_buf #(.XLEN(XLEN)) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_hold),
    .drain      (drain_hold),
    .clear      (redirect_valid),
    .load_instr (imem_rdata),
    .load_pc    (inflight_pc),
    .instr      (hold_instr),
    .pc         (hold_pc),
    .hold_valid (hold_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      ifid_instr  <= NOP_INSTR;
      ifid_pc     <= '0;
      ifid_valid  <= 1'b0;
    end else if (redirect_valid) begin
      state      <= RUN;
      pc         <= redirect_pc;
      inflight   <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else begin
      if (imem_req) begin
        pc          <= pc + XLEN'(1);
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end

      unique case (state)
        RUN: begin
          if (ifid_write) begin
            if (inflight) begin
              ifid_instr <= imem_rdata;
              ifid_pc    <= inflight_pc;
              ifid_valid <= 1'b1;
            end else begin
              ifid_instr <= NOP_INSTR;
              ifid_valid <= 1'b0;
            end
          end else if (inflight) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (ifid_write) begin
            ifid_instr <= hold_instr;
            ifid_pc    <= hold_pc;
            ifid_valid <= 1'b1;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ifid_write && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (redirect_valid && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a 1-cycle-latency instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        ifid_write;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        pw;
    logic        iw;
    logic        rv;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
  } vec_t;

  vec_t vecs[22];

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_valid     (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns addr+0x1000 one cycle after a request, garbage otherwise
  always @(posedge clk) imem_rdata <= imem_req ? imem_addr + 16'h1000 : 16'hDEAD;

  function automatic vec_t mk(input logic pw, input logic iw, input logic rv,
                              input logic [15:0] rpc, input logic e_req,
                              input logic [15:0] e_addr, input logic e_valid,
                              input logic [15:0] e_pc, input logic [15:0] e_instr);
    vec_t v;
    v.pw = pw; v.iw = iw; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passes++;
  endtask

  // Entry/exit: just after a rising edge; checks land on the falling edge
  task automatic run_vec(input string tag, input vec_t v);
    pc_write = v.pw; ifid_write = v.iw; redirect_valid = v.rv; redirect_pc = v.rpc;
    @(negedge clk);
    chk({tag, " imem_req"},   16'(imem_req),   16'(v.e_req));
    chk({tag, " imem_addr"},  imem_addr,       v.e_addr);
    chk({tag, " ifid_valid"}, 16'(ifid_valid), 16'(v.e_valid));
    chk({tag, " ifid_pc"},    ifid_pc,         v.e_pc);
    chk({tag, " ifid_instr"}, ifid_instr,      v.e_instr);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pc_write = 1'b1; ifid_write = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    chk("rst imem_req", 16'(imem_req), 16'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst imem_req2",   16'(imem_req),   16'h0);
    chk("rst ifid_valid",  16'(ifid_valid), 16'h0);
    chk("rst ifid_pc",     ifid_pc,         16'h0000);
    chk("rst ifid_instr",  ifid_instr,      16'h0000);
`ifdef FETCH_PERF_CNT_EN
    chk("rst stall_cnt", stall_cnt, 16'h0);
    chk("rst flush_cnt", flush_cnt, 16'h0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Free run, 1-cycle stall, 3-cycle stall, redirect while holding
    vecs[0]  = mk(1, 1, 0, 16'h0,  1, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[1]  = mk(1, 1, 0, 16'h0,  1, 16'h0001, 0, 16'h0000, 16'h0000);
    vecs[2]  = mk(1, 1, 0, 16'h0,  1, 16'h0002, 1, 16'h0000, 16'h1000);
    vecs[3]  = mk(1, 1, 0, 16'h0,  1, 16'h0003, 1, 16'h0001, 16'h1001);
    vecs[4]  = mk(1, 1, 0, 16'h0,  1, 16'h0004, 1, 16'h0002, 16'h1002);
    vecs[5]  = mk(0, 0, 0, 16'h0,  0, 16'h0005, 1, 16'h0003, 16'h1003);
    vecs[6]  = mk(1, 1, 0, 16'h0,  0, 16'h0005, 1, 16'h0003, 16'h1003);
    vecs[7]  = mk(1, 1, 0, 16'h0,  1, 16'h0005, 1, 16'h0004, 16'h1004);
    vecs[8]  = mk(1, 1, 0, 16'h0,  1, 16'h0006, 0, 16'h0004, 16'h0000);
    vecs[9]  = mk(1, 1, 0, 16'h0,  1, 16'h0007, 1, 16'h0005, 16'h1005);
    vecs[10] = mk(0, 0, 0, 16'h0,  0, 16'h0008, 1, 16'h0006, 16'h1006);
    vecs[11] = mk(1, 0, 0, 16'h0,  0, 16'h0008, 1, 16'h0006, 16'h1006);
    vecs[12] = mk(1, 0, 0, 16'h0,  0, 16'h0008, 1, 16'h0006, 16'h1006);
    vecs[13] = mk(1, 1, 0, 16'h0,  0, 16'h0008, 1, 16'h0006, 16'h1006);
    vecs[14] = mk(1, 1, 0, 16'h0,  1, 16'h0008, 1, 16'h0007, 16'h1007);
    vecs[15] = mk(1, 1, 0, 16'h0,  1, 16'h0009, 0, 16'h0007, 16'h0000);
    vecs[16] = mk(0, 0, 0, 16'h0,  0, 16'h000A, 1, 16'h0008, 16'h1008);
    vecs[17] = mk(1, 0, 1, 16'h40, 0, 16'h000A, 1, 16'h0008, 16'h1008);
    vecs[18] = mk(1, 1, 0, 16'h0,  1, 16'h0040, 0, 16'h0008, 16'h0000);
    vecs[19] = mk(1, 1, 0, 16'h0,  1, 16'h0041, 0, 16'h0008, 16'h0000);
    vecs[20] = mk(1, 1, 0, 16'h0,  1, 16'h0042, 1, 16'h0040, 16'h1040);
    vecs[21] = mk(1, 1, 0, 16'h0,  1, 16'h0043, 1, 16'h0041, 16'h1041);

    do_reset();
    for (int i = 0; i < 22; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Redirect together with a full stall: redirect wins, no HOLD entered
    run_vec("rs0", mk(0, 0, 1, 16'h0100, 0, 16'h0044, 1, 16'h0042, 16'h1042));
    run_vec("rs1", mk(1, 1, 0, 16'h0,    1, 16'h0100, 0, 16'h0042, 16'h0000));
    run_vec("rs2", mk(1, 1, 0, 16'h0,    1, 16'h0101, 0, 16'h0042, 16'h0000));
    // PC wrap from 0xFFFF
    run_vec("wr0", mk(1, 1, 1, 16'hFFFF, 0, 16'h0102, 1, 16'h0100, 16'h1100));
    run_vec("wr1", mk(1, 1, 0, 16'h0,    1, 16'hFFFF, 0, 16'h0100, 16'h0000));
    run_vec("wr2", mk(1, 1, 0, 16'h0,    1, 16'h0000, 0, 16'h0100, 16'h0000));
    run_vec("wr3", mk(1, 1, 0, 16'h0,    1, 16'h0001, 1, 16'hFFFF, 16'h0FFF));
    run_vec("wr4", mk(0, 0, 0, 16'h0,    0, 16'h0002, 1, 16'h0000, 16'h1000));
    // Now in HOLD: reset must drop the parked entry
    do_reset();
    run_vec("rh0", mk(1, 1, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 16'h0000));
    run_vec("rh1", mk(1, 1, 0, 16'h0, 1, 16'h0001, 0, 16'h0000, 16'h0000));

`ifdef FETCH_PERF_CNT_EN
    pc_write = 1'b0; ifid_write = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    ifid_write = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0010;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("stall_cnt", stall_cnt, 16'd5);
    chk("flush_cnt", flush_cnt, 16'd1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
